// File: rtl/audio_dac_serializer.sv
// I2S DAC serializer: one 32-bit stereo word per frame, shifted out MSB first, slaved to sampled codec clocks.
// Latency: AUD_DACDAT changes 3 clk after a BCLK falling edge at the pin; MSB appears on the 2nd BCLK fall after an LR edge.
// Backpressure: audioInReady low while the holding register is full; optional macro DAC_UNDERRUN_REPEAT_EN repeats the last word on underrun.
module audio_dac_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        AUD_BCLK,
  input  logic        AUD_DACLRCK,
  input  logic [31:0] audioIn,
  input  logic        audioInValid,
  output logic        audioInReady,
  output logic        AUD_DACDAT,
  output logic        frameStart,
  output logic        underrun
);

  typedef enum logic [1:0] {SYNC, DELAY, SHIFT, PAD} state_t;

  state_t      state, state_nxt;
  logic [2:0]  bclk_sync;
  logic [1:0]  lrck_sync;
  logic        bclk_fall, lr_now, lr_prev;
  logic        lr_edge, left_edge, right_edge, right_go;
  logic [31:0] hold, shift_reg, ur_word, load_word;
  logic        hold_full;
  logic        chan;
  logic [3:0]  bit_cnt, cnt_nxt, cnt_dec;
  logic        dat_nxt;

  // Codec clocks are asynchronous: two-flop synchronizers, third BCLK flop for fall detection.
  always_ff @(posedge clk) begin
    bclk_sync <= {bclk_sync[1:0], AUD_BCLK};
    lrck_sync <= {lrck_sync[0], AUD_DACLRCK};
  end

  assign bclk_fall  = bclk_sync[2] & ~bclk_sync[1];
  assign lr_now     = lrck_sync[1];
  assign lr_edge    = bclk_fall && (lr_now != lr_prev);
  assign left_edge  = lr_edge && !lr_now;
  assign right_edge = lr_edge && lr_now;
  // Right-going edges only count once we are locked to a left channel.
  assign right_go   = right_edge && (state != SYNC);

  assign audioInReady = !hold_full && !rst;
  assign load_word    = hold_full ? hold : ur_word;

`ifdef DAC_UNDERRUN_REPEAT_EN
  logic [31:0] last_word;

  // Remember the most recently loaded word so an underrun can replay it.
  always_ff @(posedge clk) begin
    if (rst)
      last_word <= '0;
    else if (left_edge)
      last_word <= load_word;
  end

  assign ur_word = last_word;
`else
  assign ur_word = '0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= SYNC;
    else
      state <= state_nxt;
  end

  // Next state: LR edges preempt whatever channel is in progress.
  always_comb begin
    state_nxt = state;
    if (bclk_fall) begin
      if (left_edge || right_go) begin
        state_nxt = DELAY;
      end else begin
        case (state)
          DELAY:   state_nxt = SHIFT;
          SHIFT:   state_nxt = (bit_cnt == 4'd0) ? PAD : SHIFT;
          default: state_nxt = state;
        endcase
      end
    end
  end

  // Output decode: next serial bit and bit counter, evaluated only on BCLK falls.
  always_comb begin
    dat_nxt = AUD_DACDAT;
    cnt_nxt = bit_cnt;
    cnt_dec = bit_cnt - 4'd1;
    if (bclk_fall) begin
      dat_nxt = 1'b0;
      if (!(left_edge || right_go)) begin
        case (state)
          DELAY: begin
            dat_nxt = shift_reg[{~chan, 4'hF}];
            cnt_nxt = 4'd15;
          end
          SHIFT: begin
            if (bit_cnt != 4'd0) begin
              dat_nxt = shift_reg[{~chan, cnt_dec}];
              cnt_nxt = cnt_dec;
            end
          end
          default: dat_nxt = 1'b0;
        endcase
      end
    end
  end

  // Datapath: holding register, frame load on left edges, registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      AUD_DACDAT <= 1'b0;
      frameStart <= 1'b0;
      underrun   <= 1'b0;
      hold_full  <= 1'b0;
      hold       <= '0;
      shift_reg  <= '0;
      lr_prev    <= 1'b1;
      chan       <= 1'b0;
      bit_cnt    <= 4'd0;
    end else begin
      frameStart <= 1'b0;
      underrun   <= 1'b0;
      AUD_DACDAT <= dat_nxt;
      bit_cnt    <= cnt_nxt;
      if (bclk_fall)
        lr_prev <= lr_now;
      if (left_edge) begin
        shift_reg  <= load_word;
        hold_full  <= 1'b0;
        frameStart <= 1'b1;
        underrun   <= !hold_full;
        chan       <= 1'b0;
      end else if (right_go) begin
        chan <= 1'b1;
      end
      // Ready is low whenever hold is full, so this never collides with a real load.
      if (audioInValid && audioInReady) begin
        hold      <= audioIn;
        hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: frame table plus back-to-back and mid-frame reset sequences.
// BCLK runs 4 clk low / 4 clk high; DACDAT is sampled at each BCLK rise like the codec.
// Underrun expectations follow DAC_UNDERRUN_REPEAT_EN when the bench is built with it.
module tb_audio_dac_serializer;

  logic        clk = 1'b0;
  logic        rst, AUD_BCLK, AUD_DACLRCK, audioInValid;
  logic [31:0] audioIn;
  logic        audioInReady, AUD_DACDAT, frameStart, underrun;

  audio_dac_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_DACLRCK  (AUD_DACLRCK),
    .audioIn      (audioIn),
    .audioInValid (audioInValid),
    .audioInReady (audioInReady),
    .AUD_DACDAT   (AUD_DACDAT),
    .frameStart   (frameStart),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int fs_total = 0;
  int ur_total = 0;
  int b2b_wait;

`ifdef DAC_UNDERRUN_REPEAT_EN
  localparam logic [15:0] UR_L = 16'h1234;
  localparam logic [15:0] UR_R = 16'h5678;
`else
  localparam logic [15:0] UR_L = 16'h0000;
  localparam logic [15:0] UR_R = 16'h0000;
`endif

  typedef struct {
    bit          supply;
    logic [31:0] word;
    int          len;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
    int          exp_fs;
    int          exp_ur;
  } vec_t;

  vec_t vecs[6];

  always @(negedge clk) begin
    if (frameStart) fs_total++;
    if (underrun) ur_total++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Sample k is taken at the BCLK rise of the k-th bit period after the LR edge.
  function automatic logic [31:0] exp_samp(input logic [15:0] d, input int len);
    logic [31:0] r;
    r = '0;
    for (int k = 1; k <= 16; k++)
      if (k < len) r[k] = d[16-k];
    return r;
  endfunction

  task automatic run_chan(input logic lr, input int len, output logic [31:0] samp);
    samp = '0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      AUD_BCLK = 1'b0;
      AUD_DACLRCK = lr;
      repeat (4) @(negedge clk);
      samp[c] = AUD_DACDAT;
      AUD_BCLK = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic run_frame(input int len, output logic [31:0] ls, output logic [31:0] rs,
                           output int fs, output int ur);
    int fs0, ur0;
    fs0 = fs_total;
    ur0 = ur_total;
    run_chan(1'b0, len, ls);
    run_chan(1'b1, len, rs);
    @(negedge clk);
    fs = fs_total - fs0;
    ur = ur_total - ur0;
  endtask

  task automatic send(input logic [31:0] w);
    int t;
    @(negedge clk);
    audioIn = w;
    audioInValid = 1'b1;
    t = 0;
    while (!audioInReady && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", {31'd0, audioInReady}, 32'd1);
    @(negedge clk);
    audioInValid = 1'b0;
  endtask

  initial begin
    logic [31:0] ls, rs, s;
    int fs, ur;

    vecs[0] = '{1'b1, 32'h8001_7FFE, 32, 16'h8001, 16'h7FFE, 1, 0};
    vecs[1] = '{1'b1, 32'h1234_5678, 32, 16'h1234, 16'h5678, 1, 0};
    vecs[2] = '{1'b0, 32'h0000_0000, 32, UR_L,     UR_R,     1, 1};
    vecs[3] = '{1'b1, 32'hA5A5_0F0F, 32, 16'hA5A5, 16'h0F0F, 1, 0};
    vecs[4] = '{1'b1, 32'hFFFF_FFFF, 12, 16'hFFFF, 16'hFFFF, 1, 0};
    vecs[5] = '{1'b1, 32'h8001_7FFE, 32, 16'h8001, 16'h7FFE, 1, 0};

    rst = 1'b1;
    AUD_BCLK = 1'b1;
    AUD_DACLRCK = 1'b1;
    audioInValid = 1'b0;
    audioIn = '0;
    repeat (4) @(negedge clk);
    check("rst_ready", {31'd0, audioInReady}, 32'd0);
    check("rst_dacdat", {31'd0, AUD_DACDAT}, 32'd0);
    check("rst_framestart", {31'd0, frameStart}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, audioInReady}, 32'd1);

    // A few right-channel bit periods with no edge: the FSM stays in SYNC.
    run_chan(1'b1, 4, s);
    check("sync_idle_zero", s, 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].supply) send(vecs[v].word);
      run_frame(vecs[v].len, ls, rs, fs, ur);
      check($sformatf("v%0d_left", v), ls, exp_samp(vecs[v].exp_l, vecs[v].len));
      check($sformatf("v%0d_right", v), rs, exp_samp(vecs[v].exp_r, vecs[v].len));
      check($sformatf("v%0d_framestart", v), fs, vecs[v].exp_fs);
      check($sformatf("v%0d_underrun", v), ur, vecs[v].exp_ur);
    end

    // Back-to-back: A accepted, B waits until the left edge frees the holding register.
    @(negedge clk);
    audioIn = 32'hC3C3_3C3C;
    audioInValid = 1'b1;
    check("b2b_ready_a", {31'd0, audioInReady}, 32'd1);
    @(negedge clk);
    audioIn = 32'h0001_8000;
    check("b2b_ready_drop", {31'd0, audioInReady}, 32'd0);
    fork
      run_frame(32, ls, rs, fs, ur);
      begin
        b2b_wait = 0;
        while (!audioInReady && b2b_wait < 600) begin
          @(negedge clk);
          b2b_wait++;
        end
        check("b2b_ready_rise", {31'd0, audioInReady}, 32'd1);
        check("b2b_fs_with_ready", {31'd0, frameStart}, 32'd1);
        @(negedge clk);
        audioInValid = 1'b0;
        check("b2b_b_taken", {31'd0, audioInReady}, 32'd0);
      end
    join
    check("b2b_a_left", ls, exp_samp(16'hC3C3, 32));
    check("b2b_a_right", rs, exp_samp(16'h3C3C, 32));
    run_frame(32, ls, rs, fs, ur);
    check("b2b_b_left", ls, exp_samp(16'h0001, 32));
    check("b2b_b_right", rs, exp_samp(16'h8000, 32));
    check("b2b_b_underrun", ur, 0);

    // Reset in the middle of a left channel.
    send(32'hFFFF_FFFF);
    run_chan(1'b0, 8, s);
    check("prerst_left", s, exp_samp(16'hFFFF, 8));
    check("prerst_dacdat", {31'd0, AUD_DACDAT}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_dacdat", {31'd0, AUD_DACDAT}, 32'd0);
    check("midrst_ready", {31'd0, audioInReady}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_ready", {31'd0, audioInReady}, 32'd1);
    run_chan(1'b0, 24, s);
    check("postrst_left_zero", s, 32'd0);
    run_chan(1'b1, 2, s);
    check("postrst_right_a_zero", s, 32'd0);
    send(32'h8001_7FFE);
    run_chan(1'b1, 30, s);
    check("postrst_right_b_zero", s, 32'd0);
    run_frame(32, ls, rs, fs, ur);
    check("resume_left", ls, exp_samp(16'h8001, 32));
    check("resume_right", rs, exp_samp(16'h7FFE, 32));
    check("resume_framestart", fs, 1);
    check("resume_underrun", ur, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_dac_serializer.md
# audio_dac_serializer

Transmit end of the codec audio path: accepts one 32-bit stereo sample word (left in [31:16], right in [15:0]) per frame from the filter stage over a valid/ready handshake and shifts it out serially on AUD_DACDAT in I2S format, slaved to the codec-driven AUD_BCLK and AUD_DACLRCK. All logic runs on the single system clock; the codec clocks are sampled, not used as clocks. It sits between the audio processing chain and the codec DAC pin.

## Interface
- No parameters; sample width fixed at 16 bits per channel.
- clk  input  1  system clock, at least 8x AUD_BCLK frequency
- rst  input  1  synchronous, active-high reset
- AUD_BCLK  input  1  codec bit clock, asynchronous to clk
- AUD_DACLRCK  input  1  codec DAC LR clock, low = left, high = right; asynchronous to clk
- audioIn  input  32  sample word, [31:16] left, [15:0] right, two's complement
- audioInValid  input  1  audioIn holds a sample
- audioInReady  output  1  holding register empty; transfer on valid && ready
- AUD_DACDAT  output  1  serial data to codec, MSB first
- frameStart  output  1  one-clk pulse when a sample word is committed to a left channel
- underrun  output  1  one-clk pulse when a left channel starts with the holding register empty

## Operation
- AUD_BCLK and AUD_DACLRCK each pass through a 2-flop synchronizer; a third flop on BCLK gives bclkFall, a one-clk pulse per BCLK falling edge. All state changes below occur only on bclkFall clocks.
- lrPrev holds synced LRCK from the previous bclkFall; an LR edge is synced LRCK != lrPrev at bclkFall.
- Holding register hold[31:0] with flag holdFull. audioInReady = !holdFull && !rst. Accept sets holdFull and captures audioIn.
- FSM states: SYNC, DELAY, SHIFT, PAD.
  - SYNC (after reset): AUD_DACDAT = 0; ignores right-going edges; on the first left-going edge (1->0) enters DELAY.
  - On any left-going edge: load shift[31:0] from hold and clear holdFull, pulse frameStart; if holdFull is 0, pulse underrun and load the underrun word (see Configuration). Channel = left.
  - On a right-going edge (0->1): channel = right, shift pointer moves to bits [15:0], enter DELAY.
  - DELAY: one BCLK of I2S delay; AUD_DACDAT holds 0; next bclkFall drives bit 15 of current channel, bitCnt = 15, enter SHIFT.
  - SHIFT: each bclkFall drives the next lower bit; after bit 0 has been driven for one BCLK, enter PAD.
  - PAD: AUD_DACDAT = 0 until the next LR edge.
- An LR edge in any state takes priority: current channel is abandoned, new channel starts in DELAY (left edge also reloads from hold). Truncated channels are not resumed.
- Accept and left-load on the same clk cannot collide (ready is 0 when hold is full); if hold is empty on that clk, the load is an underrun and the incoming word is captured into hold for the next frame.

## Timing
- Reset values: AUD_DACDAT 0, frameStart 0, underrun 0, holdFull 0, state SYNC, lrPrev 1, shift 0, last-sample register 0. audioInReady is 0 during rst and 1 on the first clk after.
- Pin-to-pin: AUD_DACDAT changes 3 clk after the AUD_BCLK falling edge at the pin (2 sync + 1 edge-detect register); output registered.
- Codec samples AUD_DACDAT on BCLK rising; requires BCLK high and low phases each at least 4 clk periods.
- Per channel: MSB appears on the second BCLK falling edge after the LR transition; 16 data bits then zeros.
- frameStart/underrun assert on the same clk as the left-going edge is detected.
- Reset mid-frame: next clk is SYNC; no data output until the next left-going edge.

## Configuration
- DAC_UNDERRUN_REPEAT_EN defined: underrun word = last word loaded into shift (sample repeat).
- Not defined: underrun word = 32'h00000000 (silence). underrun pulse behaves identically in both builds.

## Test plan
- Reset then audioInValid with audioIn=32'h8001_7FFE, 64-BCLK frames -> left bits 1000000000000001 then right 0111111111111110, each MSB on 2nd BCLK fall after LR edge, zeros after, frameStart once.
- No sample supplied for a frame after sending 32'h1234_5678 -> underrun pulse; DACDAT all zeros (macro off) or 1234/5678 repeated (macro on).
- Back-to-back: valid held high with words A, B -> ready drops after A, rises on the left edge that loads A, B accepted next clk; B appears exactly one frame after A.
- Short frames, 12 BCLK per channel with 32'hFFFF_FFFF -> 11 ones per channel, truncated, next channel starts cleanly in DELAY.
- rst asserted mid-left-channel -> DACDAT 0 next clk, ready 1 after rst drops, right-going edge ignored, transmission resumes at next left-going edge.
